// File: rtl/line_memory.sv
// Line-granular storage behind a fixed-latency request/response handshake.
// One request in flight at a time; reads return a registered line one cycle after completion.
module line_memory #(
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_LINES  = 256,
   parameter int DELAY      = 50
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    is_input_valid,
   input  logic [31:0]             addr,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [BLOCK_SIZE*8-1:0] din,
   output logic                    mem_ready,
   output logic                    is_output_valid,
   output logic [BLOCK_SIZE*8-1:0] dout,
   output logic [31:0]             num_reads,
   output logic [31:0]             num_writes
);

   localparam int W      = BLOCK_SIZE * 8;
   localparam int LINE_W = $clog2(NUM_LINES);
   localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   // Handshake: a request is taken on a rising edge where mem_ready and
   // is_input_valid are both 1; is_output_valid marks the single cycle dout is new.
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [W-1:0]        din_q, din_d;
   logic [W-1:0]        dout_q, dout_d;
   logic                valid_q, valid_d;
   logic [31:0]         num_reads_q, num_reads_d;
   logic [31:0]         num_writes_q, num_writes_d;
   logic                mem_we;
   logic [W-1:0]        mem_q [NUM_LINES];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      line_d       = line_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      din_d        = din_q;
      dout_d       = dout_q;
      valid_d      = 1'b0;
      num_reads_d  = num_reads_q;
      num_writes_d = num_writes_q;
      mem_we       = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_input_valid) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
               line_d  = addr[LINE_W-1:0];
               wr_d    = mem_write;
               // A request flagged as both read and write is a write.
               rd_d    = mem_read & ~mem_write;
               din_d   = din;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               if (wr_q) begin
                  mem_we       = 1'b1;
                  num_writes_d = num_writes_q + 32'd1;
               end else if (rd_q) begin
                  valid_d     = 1'b1;
                  dout_d      = mem_q[line_q];
                  num_reads_d = num_reads_q + 32'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         line_q       <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         din_q        <= '0;
         dout_q       <= '0;
         valid_q      <= 1'b0;
         num_reads_q  <= '0;
         num_writes_q <= '0;
         for (int i = 0; i < NUM_LINES; i++) mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         line_q       <= line_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         din_q        <= din_d;
         dout_q       <= dout_d;
         valid_q      <= valid_d;
         num_reads_q  <= num_reads_d;
         num_writes_q <= num_writes_d;
         if (mem_we) mem_q[line_q] <= din_q;
      end
   end

   assign mem_ready       = (state_q == IDLE);
   assign is_output_valid = valid_q;
   assign dout            = dout_q;
   assign num_reads       = num_reads_q;
   assign num_writes      = num_writes_q;

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 16, line width in bytes (data buses are BLOCK_SIZE*8 bits).
REQ-002 SHALL have parameter NUM_LINES, default 256, storage depth in lines (power of two, >= 2).
REQ-003 SHALL have parameter DELAY, default 50, request-to-completion latency in cycles (>= 1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 is_input_valid  input  1  request present this cycle.
REQ-007 addr  input  32  line address (byte address already shifted right by log2(BLOCK_SIZE)).
REQ-008 mem_read  input  1  request is a line read.
REQ-009 mem_write  input  1  request is a line write.
REQ-010 din  input  BLOCK_SIZE*8  write line data.
REQ-011 mem_ready  output  1  responder idle and will accept a request this cycle.
REQ-012 is_output_valid  output  1  dout holds read data this cycle.
REQ-013 dout  output  BLOCK_SIZE*8  read line data.
REQ-014 num_reads / num_writes  output  32 each  completed read / write counts.

Function
REQ-015 SHALL implement two states, IDLE and BUSY; mem_ready = 1 exactly when state is IDLE.
REQ-016 SHALL accept a request on a rising edge where state is IDLE and is_input_valid = 1; it SHALL latch addr, mem_read, mem_write and din, load the delay counter with DELAY-1, and enter BUSY.
REQ-017 SHALL ignore is_input_valid and all request inputs while in BUSY; no queuing of a second request.
REQ-018 SHALL decrement the counter on each edge in BUSY. On the edge where the counter is 0, it SHALL complete the request and return to IDLE.
REQ-019 Completion of a read SHALL register mem[line] into dout and assert is_output_valid for exactly one cycle, the cycle following the completing edge. For an accept at edge E0, that is the cycle after edge E0+DELAY.
REQ-020 During the is_output_valid cycle, mem_ready SHALL already be 1. A new request accepted at the end of that cycle is legal.
REQ-021 Completion of a write SHALL store the latched din into mem[line] on the completing edge and SHALL NOT assert is_output_valid.
REQ-022 line = latched addr modulo NUM_LINES (low log2(NUM_LINES) bits); higher bits are ignored, with no error.
REQ-023 mem_read = mem_write = 1 SHALL be treated as a write only. mem_read = mem_write = 0 SHALL complete after DELAY with no array change, no is_output_valid, and no counter increment.
REQ-024 dout SHALL hold its last registered value outside is_output_valid cycles.
REQ-025 A read accepted after a write to the same line completes SHALL return the written data.
REQ-026 num_reads / num_writes SHALL each increment by 1 on the completing edge of a read / write and wrap modulo 2^32.
REQ-027 The delay counter SHALL be sized to hold DELAY-1; DELAY = 1 SHALL complete on the edge following acceptance.

Reset
REQ-028 On a reset edge: state = IDLE, counter = 0, is_output_valid = 0, dout = 0, num_reads = num_writes = 0, all NUM_LINES lines = 0.
REQ-029 Reset SHALL take priority over acceptance and completion. A reset during BUSY SHALL abort the request (no array write, no is_output_valid), and mem_ready = 1 in the cycle after the reset edge.

Verification
REQ-030 After reset, read line 5 (DELAY = 50) -> mem_ready = 0 for 50 cycles; then a single is_output_valid cycle with dout = 0, mem_ready = 1; num_reads = 1.
REQ-031 Write line 3 with 0x00112233_44556677_8899AABB_CCDDEEFF, then read line 3 -> read returns the same 128-bit value; no is_output_valid pulse during the write; num_writes = 1.
REQ-032 is_input_valid held at 1 with a changing addr throughout BUSY -> only the first request is served; the line written is the one latched at acceptance.
REQ-033 Write addr 0x0000_0103 with NUM_LINES = 256, then read addr 0x0000_0003 -> write data returned.
REQ-034 Assert reset 10 cycles into a write of line 7 -> line 7 stays 0 on a later read; num_writes = 0.
REQ-035 DELAY = 1, back-to-back reads issued on every mem_ready cycle -> one is_output_valid every 2 cycles, with the correct data each time.
